// File: rtl/wb_mux_pkg.sv
// Shared types for the registered Wishbone N-port mux: FSM states, response
// encoding and the watchdog counter width.
package wb_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RSP_ACK = 2'd0,
        RSP_ERR = 2'd1,
        RSP_RTY = 2'd2
    } rsp_e;

    localparam int TMO_CNT_W = 16;

    // Caller guarantees at least one of ack/err/rty is set; rty is the fallback.
    function automatic rsp_e rsp_prio(input logic ack, input logic err);
        if (ack) begin
            return RSP_ACK;
        end else if (err) begin
            return RSP_ERR;
        end
        return RSP_RTY;
    endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational address/mask decoder: reports whether any slave matches and the
// lowest matching slave index.
module wb_addr_decode
    import wb_mux_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    parameter int IDX_W      = 2,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDR = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
    input  logic [ADDR_WIDTH-1:0] adr_i,
    output logic                  match_o,
    output logic [IDX_W-1:0]      idx_o
);

    always_comb begin
        match_o = 1'b0;
        idx_o   = '0;
        // Walk downwards so the lowest matching index is the one left standing.
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (((adr_i ^ SLAVE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH])
                 & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == '0) begin
                match_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_mux_n_reg.sv
// Registered one-master / NUM_SLAVES-slave Wishbone classic interconnect with
// decode-miss error, master abort and optional watchdog (WB_MUX_TIMEOUT_EN).
module wb_mux_n_reg
    import wb_mux_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDR = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            wbm_adr_i,
    input  logic [DATA_WIDTH-1:0]            wbm_dat_i,
    output logic [DATA_WIDTH-1:0]            wbm_dat_o,
    input  logic                             wbm_we_i,
    input  logic [SELECT_WIDTH-1:0]          wbm_sel_i,
    input  logic                             wbm_stb_i,
    input  logic                             wbm_cyc_i,
    output logic                             wbm_ack_o,
    output logic                             wbm_err_o,
    output logic                             wbm_rty_o,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0] wbs_adr_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_i,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_o,
    output logic [NUM_SLAVES-1:0]            wbs_we_o,
    output logic [NUM_SLAVES*SELECT_WIDTH-1:0] wbs_sel_o,
    output logic [NUM_SLAVES-1:0]            wbs_stb_o,
    output logic [NUM_SLAVES-1:0]            wbs_cyc_o,
    input  logic [NUM_SLAVES-1:0]            wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]            wbs_err_i,
    input  logic [NUM_SLAVES-1:0]            wbs_rty_i
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
    begin : g_param_chk
        $error("wb_mux_n_reg: NUM_SLAVES or TIMEOUT_CYCLES out of range");
    end

    state_e                  state_q;
    rsp_e                    rsp_q;
    logic [IDX_W-1:0]        idx_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic                    we_q;
    logic [SELECT_WIDTH-1:0] sel_q;
    logic [NUM_SLAVES-1:0]   stb_q;
    logic [DATA_WIDTH-1:0]   rdat_q;
    logic [DATA_WIDTH-1:0]   mdat_q;
    logic                    ack_q;
    logic                    err_q;
    logic                    rty_q;
`ifdef WB_MUX_TIMEOUT_EN
    localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_CNT_W-1:0]    tmo_cnt_q;
`endif

    logic                    dec_match;
    logic [IDX_W-1:0]        dec_idx;
    logic [NUM_SLAVES-1:0]   dec_onehot;
    logic                    slv_ack;
    logic                    slv_err;
    logic                    slv_rty;
    logic [DATA_WIDTH-1:0]   slv_dat;
    logic                    rsp_visible;

    wb_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_W      (IDX_W),
        .SLAVE_ADDR (SLAVE_ADDR),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .adr_i   (wbm_adr_i),
        .match_o (dec_match),
        .idx_o   (dec_idx)
    );

    always_comb begin
        dec_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            dec_onehot[i] = (dec_idx == IDX_W'(i));
        end
    end

    assign slv_ack     = wbs_ack_i[idx_q];
    assign slv_err     = wbs_err_i[idx_q];
    assign slv_rty     = wbs_rty_i[idx_q];
    assign slv_dat     = wbs_dat_i[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    // While the master is looking at a response its request is still the old
    // one; accepting it would replay the transfer.
    assign rsp_visible = ack_q | err_q | rty_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rsp_q   <= RSP_ACK;
            idx_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            stb_q   <= '0;
            rdat_q  <= '0;
            mdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
`ifdef WB_MUX_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            rty_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wbm_cyc_i && wbm_stb_i && !rsp_visible) begin
                        adr_q <= wbm_adr_i;
                        dat_q <= wbm_dat_i;
                        we_q  <= wbm_we_i;
                        sel_q <= wbm_sel_i;
                        idx_q <= dec_idx;
                        if (dec_match) begin
                            stb_q   <= dec_onehot;
                            state_q <= ACTIVE;
`ifdef WB_MUX_TIMEOUT_EN
                            tmo_cnt_q <= '0;
`endif
                        end else begin
                            rsp_q   <= RSP_ERR;
                            rdat_q  <= '0;
                            state_q <= RESP;
                        end
                    end
                end
                ACTIVE: begin
                    // Abort outranks any slave response arriving in the same cycle.
                    if (!wbm_cyc_i) begin
                        stb_q   <= '0;
                        state_q <= IDLE;
                    end else if (slv_ack || slv_err || slv_rty) begin
                        rsp_q   <= rsp_prio(slv_ack, slv_err);
                        rdat_q  <= slv_ack ? slv_dat : '0;
                        stb_q   <= '0;
                        state_q <= RESP;
                    end
`ifdef WB_MUX_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_LIMIT) begin
                        rsp_q   <= RSP_ERR;
                        rdat_q  <= '0;
                        stb_q   <= '0;
                        state_q <= RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    ack_q   <= (rsp_q == RSP_ACK);
                    err_q   <= (rsp_q == RSP_ERR);
                    rty_q   <= (rsp_q == RSP_RTY);
                    mdat_q  <= rdat_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slv
        assign wbs_adr_o[i*ADDR_WIDTH +: ADDR_WIDTH]     = adr_q;
        assign wbs_dat_o[i*DATA_WIDTH +: DATA_WIDTH]     = dat_q;
        assign wbs_sel_o[i*SELECT_WIDTH +: SELECT_WIDTH] = sel_q;
    end

    assign wbs_stb_o = stb_q;
    assign wbs_cyc_o = stb_q;
    assign wbs_we_o  = stb_q & {NUM_SLAVES{we_q}};
    assign wbm_dat_o = mdat_q;
    assign wbm_ack_o = ack_q;
    assign wbm_err_o = err_q;
    assign wbm_rty_o = rty_q;

endmodule

// File: tb/tb_wb_mux_n_reg.sv
// Directed bench for wb_mux_n_reg: 3 slaves at 0x000/0x010/0x100, timeout 8.
module tb_wb_mux_n_reg;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;
    localparam int NS = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   wbm_adr_i;
    logic [DW-1:0]   wbm_dat_i;
    logic [DW-1:0]   wbm_dat_o;
    logic            wbm_we_i;
    logic [SW-1:0]   wbm_sel_i;
    logic            wbm_stb_i;
    logic            wbm_cyc_i;
    logic            wbm_ack_o;
    logic            wbm_err_o;
    logic            wbm_rty_o;
    logic [NS*AW-1:0] wbs_adr_o;
    logic [NS*DW-1:0] wbs_dat_i;
    logic [NS*DW-1:0] wbs_dat_o;
    logic [NS-1:0]   wbs_we_o;
    logic [NS*SW-1:0] wbs_sel_o;
    logic [NS-1:0]   wbs_stb_o;
    logic [NS-1:0]   wbs_cyc_o;
    logic [NS-1:0]   wbs_ack_i;
    logic [NS-1:0]   wbs_err_i;
    logic [NS-1:0]   wbs_rty_i;

    int errors = 0;
    int checks = 0;

    wb_mux_n_reg #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .SELECT_WIDTH   (SW),
        .NUM_SLAVES     (NS),
        .SLAVE_ADDR     ({32'h0000_0100, 32'h0000_0010, 32'h0000_0000}),
        .SLAVE_MASK     ({32'h0000_0F00, 32'h0000_0FF0, 32'h0000_0FF0}),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wbm_adr_i (wbm_adr_i),
        .wbm_dat_i (wbm_dat_i),
        .wbm_dat_o (wbm_dat_o),
        .wbm_we_i  (wbm_we_i),
        .wbm_sel_i (wbm_sel_i),
        .wbm_stb_i (wbm_stb_i),
        .wbm_cyc_i (wbm_cyc_i),
        .wbm_ack_o (wbm_ack_o),
        .wbm_err_o (wbm_err_o),
        .wbm_rty_o (wbm_rty_o),
        .wbs_adr_o (wbs_adr_o),
        .wbs_dat_i (wbs_dat_i),
        .wbs_dat_o (wbs_dat_o),
        .wbs_we_o  (wbs_we_o),
        .wbs_sel_o (wbs_sel_o),
        .wbs_stb_o (wbs_stb_o),
        .wbs_cyc_o (wbs_cyc_o),
        .wbs_ack_i (wbs_ack_i),
        .wbs_err_i (wbs_err_i),
        .wbs_rty_i (wbs_rty_i)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic drive_req(input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic we);
        wbm_adr_i = adr;
        wbm_dat_i = dat;
        wbm_we_i  = we;
        wbm_sel_i = 4'hF;
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
    endtask

    task automatic drop_req;
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        wbm_we_i  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drop_req();
        wbm_adr_i = '0;
        wbm_dat_i = '0;
        wbm_sel_i = '0;
        wbs_dat_i = '0;
        wbs_ack_i = '0;
        wbs_err_i = '0;
        wbs_rty_i = '0;
        repeat (3) tick();
        checks++;
        if ({wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o, wbs_adr_o, wbs_dat_o,
             wbs_we_o, wbs_sel_o, wbs_stb_o, wbs_cyc_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: stb=%b cyc=%b ack=%b err=%b dat_o=%h, required all zero",
                     wbs_stb_o, wbs_cyc_o, wbm_ack_o, wbm_err_o, wbm_dat_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_zero_wait;
        drive_req(32'h014, 32'hDEAD_BEEF, 1'b1);
        tick();
        checks++;
        if ({wbs_stb_o, wbs_cyc_o, wbs_we_o} !== 9'b010_010_010) begin
            errors++;
            $display("FAIL wr_strobe: stb/cyc/we=%b required 010010010", {wbs_stb_o, wbs_cyc_o, wbs_we_o});
        end
        checks++;
        if ({wbs_adr_o[AW +: AW], wbs_dat_o[DW +: DW]} !== {32'h014, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL wr_payload: adr=%h dat=%h required 00000014 deadbeef",
                     wbs_adr_o[AW +: AW], wbs_dat_o[DW +: DW]);
        end
        wbs_ack_i = 3'b010;
        tick();
        wbs_ack_i = 3'b000;
        checks++;
        if ({wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o} !== 6'b000_000) begin
            errors++;
            $display("FAIL wr_release: stb=%b ack/err/rty=%b required 000 000",
                     wbs_stb_o, {wbm_ack_o, wbm_err_o, wbm_rty_o});
        end
        tick();
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b100) begin
            errors++;
            $display("FAIL wr_ack_at_3: ack/err/rty=%b required 100", {wbm_ack_o, wbm_err_o, wbm_rty_o});
        end
        drop_req();
        tick();
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b000) begin
            errors++;
            $display("FAIL wr_ack_single: ack/err/rty=%b required 000", {wbm_ack_o, wbm_err_o, wbm_rty_o});
        end
    endtask

    task automatic test_read_wait_states;
        int other_strobes = 0;
        drive_req(32'h104, 32'h0, 1'b0);
        wbs_dat_i = {32'h1234_5678, 32'hAAAA_5555, 32'h5555_AAAA};
        for (int c = 1; c <= 5; c++) begin
            tick();
            if ((wbs_stb_o[1:0] | wbs_cyc_o[1:0]) != 2'b00) other_strobes++;
            if (c == 1) begin
                checks++;
                if ({wbs_stb_o, wbs_we_o} !== 6'b100_000) begin
                    errors++;
                    $display("FAIL rd_strobe: stb=%b we=%b required 100 000", wbs_stb_o, wbs_we_o);
                end
            end
            if (c == 3) wbs_ack_i = 3'b100;
            if (c == 4) wbs_ack_i = 3'b000;
        end
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_dat_o} !== {3'b100, 32'h1234_5678}) begin
            errors++;
            $display("FAIL rd_ack_data: ack/err/rty=%b dat=%h required 100 12345678",
                     {wbm_ack_o, wbm_err_o, wbm_rty_o}, wbm_dat_o);
        end
        drop_req();
        tick();
        checks++;
        if ({wbm_ack_o, wbm_dat_o} !== {1'b0, 32'h1234_5678}) begin
            errors++;
            $display("FAIL rd_data_hold: ack=%b dat=%h required 0 12345678", wbm_ack_o, wbm_dat_o);
        end
        checks++;
        if (other_strobes !== 0) begin
            errors++;
            $display("FAIL rd_other_slaves: strobed cycles=%0d required 0", other_strobes);
        end
    endtask

    task automatic test_decode_miss;
        drive_req(32'h200, 32'h0, 1'b0);
        tick();
        checks++;
        if ({wbs_stb_o, wbs_cyc_o, wbm_err_o} !== 7'b0) begin
            errors++;
            $display("FAIL miss_early: stb=%b cyc=%b err=%b required 000 000 0", wbs_stb_o, wbs_cyc_o, wbm_err_o);
        end
        tick();
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_dat_o, wbs_stb_o} !== {3'b010, 32'h0, 3'b000}) begin
            errors++;
            $display("FAIL miss_err_at_2: ack/err/rty=%b dat=%h stb=%b required 010 00000000 000",
                     {wbm_ack_o, wbm_err_o, wbm_rty_o}, wbm_dat_o, wbs_stb_o);
        end
        drop_req();
        tick();
        checks++;
        if (wbm_err_o !== 1'b0) begin
            errors++;
            $display("FAIL miss_err_single: err=%b required 0", wbm_err_o);
        end
    endtask

    task automatic test_ack_err_priority;
        drive_req(32'h004, 32'h0, 1'b0);
        tick();
        wbs_dat_i[0 +: DW] = 32'hCAFE_F00D;
        wbs_ack_i = 3'b001;
        wbs_err_i = 3'b001;
        tick();
        wbs_ack_i = 3'b000;
        wbs_err_i = 3'b000;
        tick();
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_dat_o} !== {3'b100, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL ack_over_err: ack/err/rty=%b dat=%h required 100 cafef00d",
                     {wbm_ack_o, wbm_err_o, wbm_rty_o}, wbm_dat_o);
        end
        drop_req();
        tick();
    endtask

    task automatic test_retry;
        drive_req(32'h018, 32'h0, 1'b0);
        tick();
        wbs_dat_i[DW +: DW] = 32'h1111_2222;
        wbs_rty_i = 3'b010;
        wbs_ack_i = 3'b001;
        tick();
        wbs_rty_i = 3'b000;
        wbs_ack_i = 3'b000;
        tick();
        checks++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_dat_o} !== {3'b001, 32'h0}) begin
            errors++;
            $display("FAIL rty_only_selected: ack/err/rty=%b dat=%h required 001 00000000",
                     {wbm_ack_o, wbm_err_o, wbm_rty_o}, wbm_dat_o);
        end
        drop_req();
        tick();
    endtask

    task automatic test_abort;
        int stray = 0;
        drive_req(32'h010, 32'h0, 1'b0);
        tick();
        tick();
        checks++;
        if (wbs_stb_o !== 3'b010) begin
            errors++;
            $display("FAIL abort_stalled: stb=%b required 010", wbs_stb_o);
        end
        drop_req();
        wbs_ack_i = 3'b010;
        tick();
        wbs_ack_i = 3'b000;
        checks++;
        if ({wbs_stb_o, wbs_cyc_o} !== 6'b0) begin
            errors++;
            $display("FAIL abort_release: stb=%b cyc=%b required 000 000", wbs_stb_o, wbs_cyc_o);
        end
        for (int c = 0; c < 3; c++) begin
            if ({wbm_ack_o, wbm_err_o, wbm_rty_o} != 3'b000) stray++;
            tick();
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL abort_no_response: response cycles=%0d required 0", stray);
        end
        drive_req(32'h000, 32'h0, 1'b0);
        wbs_dat_i[0 +: DW] = 32'h0BAD_C0DE;
        tick();
        wbs_ack_i = 3'b001;
        tick();
        wbs_ack_i = 3'b000;
        tick();
        checks++;
        if ({wbm_ack_o, wbm_dat_o} !== {1'b1, 32'h0BAD_C0DE}) begin
            errors++;
            $display("FAIL abort_followup: ack=%b dat=%h required 1 0badc0de", wbm_ack_o, wbm_dat_o);
        end
        drop_req();
        tick();
    endtask

    task automatic test_reset_mid;
        int stray = 0;
        drive_req(32'h014, 32'h0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drop_req();
        checks++;
        if ({wbs_stb_o, wbs_cyc_o} !== 6'b0) begin
            errors++;
            $display("FAIL rst_mid_release: stb=%b cyc=%b required 000 000", wbs_stb_o, wbs_cyc_o);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            if ({wbm_ack_o, wbm_err_o, wbm_rty_o} != 3'b000) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL rst_mid_no_response: response cycles=%0d required 0", stray);
        end
    endtask

    task automatic test_back_to_back;
        int acks = 0;
        int s0_cycles = 0;
        int s1_cycles = 0;
        logic [DW-1:0] s0_data = '0;
        drive_req(32'h014, 32'h1357_9BDF, 1'b1);
        for (int c = 0; c < 14; c++) begin
            tick();
            wbs_ack_i = wbs_stb_o;
            if (wbs_stb_o[0]) begin
                s0_cycles++;
                s0_data = wbs_dat_o[0 +: DW];
            end
            if (wbs_stb_o[1]) s1_cycles++;
            if (wbm_ack_o) begin
                acks++;
                if (acks == 1) drive_req(32'h008, 32'h55AA_55AA, 1'b1);
                else drop_req();
            end
        end
        wbs_ack_i = 3'b000;
        drop_req();
        checks++;
        if ({acks, s1_cycles, s0_cycles} !== {32'd2, 32'd1, 32'd1}) begin
            errors++;
            $display("FAIL b2b_counts: acks=%0d s1=%0d s0=%0d required 2 1 1", acks, s1_cycles, s0_cycles);
        end
        checks++;
        if (s0_data !== 32'h55AA_55AA) begin
            errors++;
            $display("FAIL b2b_second_data: dat=%h required 55aa55aa", s0_data);
        end
        tick();
    endtask

    task automatic test_timeout;
`ifdef WB_MUX_TIMEOUT_EN
        int first_err = 0;
        int err_pulses = 0;
        logic [NS-1:0] stb_c8 = '0;
        logic [NS-1:0] stb_c9 = '1;
        drive_req(32'h104, 32'h0, 1'b0);
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 8) stb_c8 = wbs_stb_o;
            if (c == 9) stb_c9 = wbs_stb_o;
            if (wbm_err_o) begin
                err_pulses++;
                if (first_err == 0) first_err = c;
                drop_req();
            end
        end
        drop_req();
        checks++;
        if ({first_err, err_pulses} !== {32'd10, 32'd1}) begin
            errors++;
            $display("FAIL timeout_err: first at cycle %0d pulses %0d required 10 1", first_err, err_pulses);
        end
        checks++;
        if ({stb_c8, stb_c9} !== 6'b100_000) begin
            errors++;
            $display("FAIL timeout_strobe: stb@8=%b stb@9=%b required 100 000", stb_c8, stb_c9);
        end
`else
        int bad = 0;
        drive_req(32'h104, 32'h0, 1'b0);
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (wbs_stb_o != 3'b100 || {wbm_ack_o, wbm_err_o, wbm_rty_o} != 3'b000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL no_timeout_active: deviating cycles=%0d required 0", bad);
        end
        drop_req();
        tick();
        checks++;
        if (wbs_stb_o !== 3'b000) begin
            errors++;
            $display("FAIL no_timeout_abort: stb=%b required 000", wbs_stb_o);
        end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait_states();
        test_decode_miss();
        test_ack_err_priority();
        test_retry();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_mux_n_reg.md
Name: wb_mux_n_reg

Overview:
- Registered N-port Wishbone classic interconnect: one master, NUM_SLAVES slaves, address/mask decode per slave.
- Successor to the fixed two-slave mux used by the copter SoC (LED, counter). Adds:
  - parametrised slave count
  - registered request and response paths
  - decode-miss error
  - master-abort handling
  - optional bus-timeout watchdog
- Sits between the SPI/CPU Wishbone master and peripheral slaves.

Parameters:
- DATA_WIDTH, 32, data bus width (8/16/32/64).
- ADDR_WIDTH, 32, address width.
- SELECT_WIDTH, DATA_WIDTH/8, byte-select width.
- NUM_SLAVES, 4, slave port count (1..16).
- SLAVE_ADDR, 0, NUM_SLAVES*ADDR_WIDTH concatenated base addresses; slave i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- SLAVE_MASK, 0, same layout; address bits compared where mask=1.
- TIMEOUT_CYCLES, 255, watchdog limit (1..65535), used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wbm_adr_i  in  ADDR_WIDTH  master address
- wbm_dat_i  in  DATA_WIDTH  master write data
- wbm_dat_o  out  DATA_WIDTH  read data to master
- wbm_we_i  in  1  write enable
- wbm_sel_i  in  SELECT_WIDTH  byte selects
- wbm_stb_i  in  1  strobe
- wbm_cyc_i  in  1  cycle
- wbm_ack_o  out  1  acknowledge
- wbm_err_o  out  1  error
- wbm_rty_o  out  1  retry
- wbs_adr_o  out  NUM_SLAVES*ADDR_WIDTH  per-slave address
- wbs_dat_i  in  NUM_SLAVES*DATA_WIDTH  per-slave read data
- wbs_dat_o  out  NUM_SLAVES*DATA_WIDTH  per-slave write data
- wbs_we_o  out  NUM_SLAVES  write enables
- wbs_sel_o  out  NUM_SLAVES*SELECT_WIDTH  byte selects
- wbs_stb_o  out  NUM_SLAVES  strobes
- wbs_cyc_o  out  NUM_SLAVES  cycles
- wbs_ack_i  in  NUM_SLAVES  acks
- wbs_err_i  in  NUM_SLAVES  errors
- wbs_rty_i  in  NUM_SLAVES  retries

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0.
- Decode: slave i matches when ((wbm_adr_i ^ SLAVE_ADDR[i]) & SLAVE_MASK[i]) == 0.
  - Lowest matching index wins.
  - No match is a decode miss.
- IDLE:
  - On wbm_cyc_i & wbm_stb_i, latch adr/dat/we/sel and the selected index.
  - Match: go to ACTIVE. wbs_cyc_o[idx] and wbs_stb_o[idx] are asserted from the next cycle (request latency 1).
  - Miss: go to RESP with err.
- ACTIVE:
  - Selected slave sees latched adr/dat/we/sel. Non-selected slaves see stb=cyc=0; their adr/dat/sel may mirror the latched values.
  - On wbs_ack_i|wbs_err_i|wbs_rty_i[idx]:
    - Register the response type (priority ack>err>rty) and wbs_dat_i[idx].
    - Deassert slave stb/cyc next cycle.
    - Go to RESP.
  - Responses from non-selected slaves are ignored.
- RESP:
  - Exactly one cycle of wbm_ack_o, wbm_err_o or wbm_rty_o. wbm_dat_o holds the registered read data (0 on err/rty/miss).
  - Go to IDLE. The master request is not re-sampled in this cycle.
  - Total latency for a zero-wait slave: master request to master ack is 3 cycles.
- wbm_dat_o holds its last value outside RESP.
- Master abort: wbm_cyc_i low in ACTIVE → next cycle slave stb/cyc = 0, FSM to IDLE, no master response. Abort is checked before slave response in the same cycle.
- rst mid-transaction: all strobes drop next edge; no response is issued.
- Back-to-back transfers: the next request is accepted in the IDLE cycle following RESP.

Optional Feature:
- WB_MUX_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to ACTIVE and increments each ACTIVE cycle.
  - When it reaches TIMEOUT_CYCLES with no slave response: drop slave stb/cyc, go to RESP with wbm_err_o.
  - A slave response in the same cycle as the limit wins over the timeout.
- Undefined: no counter; ACTIVE waits indefinitely.

Decomposition:
- Package wb_mux_pkg holds:
  - FSM state enum {IDLE, ACTIVE, RESP}
  - response-type encoding {RSP_ACK, RSP_ERR, RSP_RTY}
  - timeout counter width constant 16
- One sub-module: wb_addr_decode, combinational, taking address, SLAVE_ADDR and SLAVE_MASK and producing match and idx.

Test Plan (NUM_SLAVES=3; bases 0x000/0x010/0x100; masks 0xFF0/0xFF0/0xF00):
- Write 0xDEADBEEF to 0x014, slave 1 acks on its first strobe cycle → wbs_stb_o=3'b010 one cycle after request; wbm_ack_o pulses exactly once 3 cycles after request.
- Read 0x104, slave 2 returns 0x12345678 with 2 wait states → wbm_dat_o=0x12345678 with the ack; slaves 0 and 1 never strobed.
- Access 0x200 (no match) → wbm_err_o single pulse 2 cycles after request; no wbs_stb_o asserted.
- Slave 0 asserts err and ack together on 0x004 → wbm_ack_o=1, wbm_err_o=0.
- Master drops cyc while slave 1 is stalled → slave stb/cyc low next cycle; no ack/err/rty; the following request to 0x000 completes normally.
- With WB_MUX_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave 2 never responds → wbm_err_o after 8 ACTIVE cycles; without the macro, still ACTIVE after 100 cycles.
